// File: rtl/abacus_top.sv
// ABACUS CPU profiler: Wishbone-slave counter block that tallies issued RV32IMA
// instructions by class and I/D-cache events, readable through a 256-byte window.
module abacus_top #(
  parameter logic [31:0] ABACUS_BASE_ADDR             = 32'hF003_0000,
  parameter bit          INCLUDE_INSTRUCTION_PROFILER = 1'b1,
  parameter bit          INCLUDE_CACHE_PROFILER       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  input  logic [31:0] abacus_instruction,
  input  logic        abacus_instruction_issued,
  input  logic        abacus_icache_request,
  input  logic        abacus_dcache_request,
  input  logic        abacus_icache_miss,
  input  logic        abacus_dcache_hit,
  input  logic        abacus_icache_line_fill_in_progress,
  input  logic        abacus_dcache_line_fill_in_progress
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned N_INSTR  = 11;
  localparam int unsigned N_CACHE  = 6;
  localparam int unsigned IDX_W    = 6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  logic                    instr_en;
  logic                    cache_en;
  logic                    sel_c;
  logic                    req_c;
  logic                    clear_c;
  logic [IDX_W-1:0]        idx_c;
  logic [CNT_W-1:0]        rdata_c;
  logic [N_INSTR-1:0]      cls_c;
  logic [N_INSTR-1:0]      instr_inc_c;
  logic [N_CACHE-1:0]      cache_inc_c;
  logic [N_INSTR-1:0][CNT_W-1:0] instr_cnt;
  logic [N_CACHE-1:0][CNT_W-1:0] cache_cnt;
  logic                    unused_c;

  assign unused_c = ^{wb_adr[1:0], wb_dat_i[31:1],
                      abacus_instruction[24:15], abacus_instruction[11:7]};

  // Bus decode: a held request completes every second cycle because ack gates req
  assign sel_c   = wb_cyc & wb_stb & (wb_adr[31:8] == ABACUS_BASE_ADDR[31:8]);
  assign req_c   = sel_c & ~wb_ack;
  assign idx_c   = wb_adr[7:2];
  assign clear_c = req_c & wb_we & (idx_c == IDX_W'(0)) & wb_dat_i[0];

  // Instruction class decode, one-hot or zero
  always_comb begin
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7z;
    logic       f7s;
    logic       alu_imm_or_reg;
    cls_c          = '0;
    op             = abacus_instruction[6:0];
    f3             = abacus_instruction[14:12];
    f7z            = (abacus_instruction[31:25] == 7'b0000000);
    f7s            = (abacus_instruction[31:25] == 7'b0100000);
    alu_imm_or_reg = (op == OP_IMM) | ((op == OP_REG) & f7z);
    cls_c[0]  = (op == OP_LOAD);
    cls_c[1]  = (op == OP_STORE);
    cls_c[2]  = (f3 == 3'b000) & alu_imm_or_reg;
    cls_c[3]  = (op == OP_REG) & (f3 == 3'b000) & f7s;
    cls_c[4]  = ((f3 == 3'b100) | (f3 == 3'b110) | (f3 == 3'b111)) & alu_imm_or_reg;
    cls_c[5]  = ((f3 == 3'b001) | (f3 == 3'b101)) & ((op == OP_IMM) | (op == OP_REG)) &
                (f7z | f7s);
    cls_c[6]  = ((f3 == 3'b010) | (f3 == 3'b011)) & alu_imm_or_reg;
    cls_c[7]  = (op == OP_BRANCH);
    cls_c[8]  = (op == OP_JAL) | (op == OP_JALR);
    cls_c[9]  = (op == OP_SYSTEM) | (op == OP_FENCE);
    cls_c[10] = (op == OP_AMO);
  end

  assign instr_inc_c = {N_INSTR{instr_en & abacus_instruction_issued}} & cls_c;
  assign cache_inc_c = {N_CACHE{cache_en}} &
                       {abacus_dcache_line_fill_in_progress, abacus_dcache_hit,
                        abacus_dcache_request, abacus_icache_line_fill_in_progress,
                        abacus_icache_miss, abacus_icache_request};

  // Counter banks; clear takes priority over a coincident increment
  if (INCLUDE_INSTRUCTION_PROFILER) begin : g_instr
    for (genvar i = 0; i < N_INSTR; i++) begin : g_cnt
      logic [CNT_W-1:0] count;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                count <= '0;
        else if (clear_c)        count <= '0;
        else if (instr_inc_c[i]) count <= count + CNT_W'(1);
      end
      assign instr_cnt[i] = count;
    end
  end else begin : g_no_instr
    assign instr_cnt = '0;
  end

  if (INCLUDE_CACHE_PROFILER) begin : g_cache
    for (genvar i = 0; i < N_CACHE; i++) begin : g_cnt
      logic [CNT_W-1:0] count;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                count <= '0;
        else if (clear_c)        count <= '0;
        else if (cache_inc_c[i]) count <= count + CNT_W'(1);
      end
      assign cache_cnt[i] = count;
    end
  end else begin : g_no_cache
    assign cache_cnt = '0;
  end

  // Read mux over the register window; unmapped and CTRL read as zero
  always_comb begin
    rdata_c = '0;
    if (idx_c == IDX_W'(1)) begin
      rdata_c = CNT_W'(instr_en);
    end else if (idx_c == IDX_W'(2)) begin
      rdata_c = CNT_W'(cache_en);
    end else if ((idx_c >= IDX_W'(4)) && (idx_c <= IDX_W'(14))) begin
      rdata_c = instr_cnt[4'(idx_c - IDX_W'(4))];
    end else if ((idx_c >= IDX_W'(16)) && (idx_c <= IDX_W'(21))) begin
      rdata_c = cache_cnt[3'(idx_c - IDX_W'(16))];
    end
  end

  // Bus response and enable registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      instr_en <= 1'b0;
      cache_en <= 1'b0;
    end else begin
      wb_ack <= req_c;
      if (req_c) begin
        if (wb_we) begin
          if (idx_c == IDX_W'(1)) instr_en <= wb_dat_i[0];
          if (idx_c == IDX_W'(2)) cache_en <= wb_dat_i[0];
        end else begin
          wb_dat_o <= rdata_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_abacus_top.sv
// Scoreboard bench for abacus_top: directed bus accesses push expected read data,
// a monitor pops and compares on every wb_ack.
module tb_abacus_top;

  localparam logic [31:0] BASE = 32'hF003_0000;

  localparam logic [31:0] I_LW    = 32'h0001_2083;
  localparam logic [31:0] I_SW    = 32'h0011_2023;
  localparam logic [31:0] I_ADDI  = 32'h0010_0093;
  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_XORI  = 32'h0010_C093;
  localparam logic [31:0] I_SRAI  = 32'h4030_D093;
  localparam logic [31:0] I_SLTU  = 32'h0031_30B3;
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_JAL   = 32'h0000_006F;
  localparam logic [31:0] I_CSRRW = 32'h3001_10F3;
  localparam logic [31:0] I_AMO   = 32'h0021_A0AF;
  localparam logic [31:0] I_LUI   = 32'h0000_10B7;
  localparam logic [31:0] I_MUL   = 32'h0231_00B3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic [31:0] abacus_instruction;
  logic        abacus_instruction_issued;
  logic        abacus_icache_request, abacus_dcache_request;
  logic        abacus_icache_miss, abacus_dcache_hit;
  logic        abacus_icache_line_fill_in_progress, abacus_dcache_line_fill_in_progress;

  typedef struct packed {
    logic        chk;
    logic [31:0] adr;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  abacus_top dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .wb_cyc                              (wb_cyc),
    .wb_stb                              (wb_stb),
    .wb_we                               (wb_we),
    .wb_adr                              (wb_adr),
    .wb_dat_i                            (wb_dat_i),
    .wb_dat_o                            (wb_dat_o),
    .wb_ack                              (wb_ack),
    .abacus_instruction                  (abacus_instruction),
    .abacus_instruction_issued           (abacus_instruction_issued),
    .abacus_icache_request               (abacus_icache_request),
    .abacus_dcache_request               (abacus_dcache_request),
    .abacus_icache_miss                  (abacus_icache_miss),
    .abacus_dcache_hit                   (abacus_dcache_hit),
    .abacus_icache_line_fill_in_progress (abacus_icache_line_fill_in_progress),
    .abacus_dcache_line_fill_in_progress (abacus_dcache_line_fill_in_progress)
  );

  // Monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    if (rst && wb_ack) begin
      sb_t e;
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_ack adr=%h dat=%h", wb_adr, wb_dat_o);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (wb_dat_o !== e.exp) begin
            n_bad++;
            $display("FAIL rd@%h got=%h exp=%h", e.adr, wb_dat_o, e.exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [31:0] exp);
    sb_t e;
    int  n;
    e.chk = ~we; e.adr = adr; e.exp = exp;
    sb_q.push_back(e);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack && n < 8);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    n_cmp++;
    if (!wb_ack) begin
      n_bad++;
      $display("FAIL ack_timeout adr=%h got=0 exp=1", adr);
      void'(sb_q.pop_back());
    end
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(wb_ack), 32'd0);
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp);
    wb_access(1'b0, BASE + off, 32'd0, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat);
    wb_access(1'b1, BASE + off, dat, 32'd0);
  endtask

  task automatic issue(input logic [31:0] ins);
    abacus_instruction = ins;
    abacus_instruction_issued = 1'b1;
    @(posedge clk); #1;
    abacus_instruction_issued = 1'b0;
  endtask

  initial begin
    logic [31:0] seq [12];
    logic [31:0] exp_cnt [11];
    int          acks;

    seq = '{I_LW, I_SW, I_ADDI, I_ADD, I_SUB, I_XORI, I_SRAI, I_SLTU,
            I_BEQ, I_JAL, I_CSRRW, I_AMO};
    exp_cnt = '{1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1};

    rst = 1'b0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_i = '0;
    abacus_instruction = '0; abacus_instruction_issued = 0;
    abacus_icache_request = 0; abacus_dcache_request = 0;
    abacus_icache_miss = 0; abacus_dcache_hit = 0;
    abacus_icache_line_fill_in_progress = 0; abacus_dcache_line_fill_in_progress = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 32'(wb_ack), 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    rd(32'h04, 32'd0);
    rd(32'h10, 32'd0);
    rd(32'h40, 32'd0);

    // Instruction classes, one per cycle back to back
    wr(32'h04, 32'd1);
    foreach (seq[i]) begin
      abacus_instruction = seq[i];
      abacus_instruction_issued = 1'b1;
      @(posedge clk); #1;
    end
    abacus_instruction_issued = 1'b0;
    for (int i = 0; i < 11; i++) rd(32'h10 + 32'(4 * i), exp_cnt[i]);

    // Disabled profiler holds counts; uncounted opcodes
    wr(32'h04, 32'd0);
    repeat (5) issue(I_LW);
    rd(32'h10, 32'd1);
    wr(32'h04, 32'd1);
    issue(I_LUI);
    issue(I_MUL);
    rd(32'h10, 32'd1);
    rd(32'h18, 32'd2);
    rd(32'h1C, 32'd1);
    rd(32'h20, 32'd1);

    // Cache events
    wr(32'h08, 32'd1);
    abacus_icache_request = 1'b1;
    repeat (4) @(posedge clk);
    #1 abacus_icache_request = 1'b0;
    abacus_dcache_hit = 1'b1;
    repeat (2) @(posedge clk);
    #1 abacus_dcache_hit = 1'b0;
    abacus_icache_line_fill_in_progress = 1'b1;
    repeat (10) @(posedge clk);
    #1 abacus_icache_line_fill_in_progress = 1'b0;
    rd(32'h40, 32'd4);
    rd(32'h50, 32'd2);
    rd(32'h48, 32'd10);
    rd(32'h44, 32'd0);
    rd(32'h4C, 32'd0);
    rd(32'h08, 32'd1);
    rd(32'h00, 32'd0);

    // Wrap from all-ones
    force dut.g_instr.g_cnt[0].count = 32'hFFFF_FFFF;
    #1 release dut.g_instr.g_cnt[0].count;
    rd(32'h10, 32'hFFFF_FFFF);
    issue(I_LW);
    rd(32'h10, 32'd0);

    // Clear coincident with an ADD increment: clear wins
    abacus_instruction = I_ADD;
    abacus_instruction_issued = 1'b1;
    fork
      begin @(posedge clk); #1 abacus_instruction_issued = 1'b0; end
    join_none
    wr(32'h00, 32'd1);
    rd(32'h18, 32'd0);
    rd(32'h40, 32'd0);
    rd(32'h1C, 32'd0);

    // Out-of-window address: no ack
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'hF004_0000;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (wb_ack) acks++; end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("no_ack_foreign", 32'(acks), 32'd0);
    @(posedge clk); #1;

    rd(32'h80, 32'd0);
    wr(32'h14, 32'h1234_5678);
    rd(32'h14, 32'd0);
    rd(32'h05, 32'd1);

    // Asynchronous reset in the middle of counting
    issue(I_SW);
    abacus_icache_request = 1'b1;
    repeat (3) @(posedge clk);
    #1 abacus_icache_request = 1'b0;
    rd(32'h14, 32'd1);
    rd(32'h40, 32'd3);
    abacus_icache_request = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_rst_dat", wb_dat_o, 32'd0);
    check("async_rst_ack", 32'(wb_ack), 32'd0);
    abacus_icache_request = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rd(32'h04, 32'd0);
    rd(32'h08, 32'd0);
    rd(32'h14, 32'd0);
    rd(32'h40, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/abacus_top.md
Name: abacus_top

Overview:
- ABACUS CPU profiler. A Wishbone-slave block that sits beside a RV32IMA core and counts issued instructions by class plus I/D-cache events.
- Software enables profiling and reads the 32-bit counters through a memory-mapped register window at ABACUS_BASE_ADDR.

Parameters:
ABACUS_BASE_ADDR, 32'hF003_0000, base of the 256-byte register window (decode on wb_adr[31:8]).
INCLUDE_INSTRUCTION_PROFILER, 1'b1, 0 removes the instruction counters; they read 0.
INCLUDE_CACHE_PROFILER, 1'b1, 0 removes the cache counters; they read 0.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
wb_cyc  in  1  Wishbone cycle.
wb_stb  in  1  Wishbone strobe.
wb_we  in  1  1 = write.
wb_adr  in  32  byte address.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data.
wb_ack  out  1  transfer acknowledge.
abacus_instruction  in  32  instruction word being issued.
abacus_instruction_issued  in  1  one-cycle qualifier; abacus_instruction is valid.
abacus_icache_request  in  1  icache request this cycle.
abacus_dcache_request  in  1  dcache request this cycle.
abacus_icache_miss  in  1  icache miss this cycle.
abacus_dcache_hit  in  1  dcache hit this cycle.
abacus_icache_line_fill_in_progress  in  1  level: icache line fill active.
abacus_dcache_line_fill_in_progress  in  1  level: dcache line fill active.

Behaviour:
Reset (rst low, async):
- All counters, enables and wb_ack go to 0.
- wb_dat_o goes to 0.

Register map (offset from base; RW = read/write, RO = read-only):
- 0x00 CTRL, write-only. bit0 = 1 clears all counters on the next edge; reads 0.
- 0x04 INSTR_EN, RW, bit0.
- 0x08 CACHE_EN, RW, bit0.
- Instruction counters, RO: 0x10 load, 0x14 store, 0x18 addition, 0x1C subtraction, 0x20 logical_bitwise, 0x24 shift_bitwise, 0x28 comparison, 0x2C branch, 0x30 jump, 0x34 system_privilege, 0x38 atomic.
- Cache counters, RO: 0x40 icache_request, 0x44 icache_miss, 0x48 icache_fill_cycles, 0x4C dcache_request, 0x50 dcache_hit, 0x54 dcache_fill_cycles.
- Unmapped offsets read 0; writes to them are ignored.
- Writes to RO registers are ignored.

Wishbone:
- A request is selected when wb_cyc & wb_stb & wb_adr[31:8] == ABACUS_BASE_ADDR[31:8]. Address bits [1:0] are ignored.
- wb_ack is registered. It is 1 for exactly one cycle, on the cycle after a selected request while wb_ack was 0. A held request therefore completes every second cycle.
- Writes take effect at the edge that raises wb_ack.
- wb_dat_o is registered at that same edge and holds its value until the next read.
- Unselected addresses get no ack.

Instruction classification (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
- load: opcode 0000011, all widths.
- store: opcode 0100011.
- addition: ADDI (0010011, f3=000), or ADD (0110011, f3=000, f7=0000000).
- subtraction: SUB (0110011, f3=000, f7=0100000).
- logical_bitwise: f3 in {100, 110, 111} on 0010011, or on 0110011 with f7=0000000.
- shift_bitwise: f3 in {001, 101} on 0010011 or 0110011 (f7 0000000 or 0100000).
- comparison: f3 in {010, 011} on 0010011, or on 0110011 with f7=0000000.
- branch: opcode 1100011.
- jump: 1101111 (JAL) or 1100111 (JALR).
- system_privilege: 1110011 (ECALL/EBREAK/CSR*/xRET/WFI) or 0001111 (FENCE).
- atomic: 0101111.
- Everything else (LUI, AUIPC, M-extension f7=0000001, illegal) is not counted.

Counting:
- Instruction counting: each cycle with abacus_instruction_issued=1 and INSTR_EN=1 increments at most one class counter by 1.
- Cache counting: with CACHE_EN=1, each counter adds 1 per clock cycle its input is high. Fill counters count cycles the level input is high.
- All counters are 32-bit and wrap from 0xFFFF_FFFF to 0.
- A CTRL clear in the same cycle as an increment: clear wins.
- An enable write takes effect from the cycle after the ack.
- Disabling a profiler holds its counts; it does not clear them.

Test Plan:
- Reset, then read 0x04, 0x10 and 0x40 -> all 0x0; wb_ack is 1 for one cycle per access.
- Write 1 to 0xF003_0004; issue LW, SW, ADDI, ADD, SUB, XORI, SRAI, SLTU, BEQ, JAL, CSRRW, AMOADD.W, one per cycle with issued=1 -> counters at 0x10..0x38 read 1,1,2,1,1,1,1,1,1,1,1.
- With INSTR_EN=0, issue 5 LW -> load count unchanged; issue LUI and MUL with INSTR_EN=1 -> no counter changes.
- Write CACHE_EN=1; hold icache_request high 4 cycles, dcache_hit 2 cycles, icache_fill 10 cycles -> 0x40=4, 0x50=2, 0x48=10.
- Force load count to 0xFFFF_FFFF, issue one LW -> reads 0; write CTRL=1 while issuing ADD -> addition count reads 0.
- Access to 0xF004_0000 -> no ack; read of unmapped 0x80 -> 0 with ack; assert rst mid-count -> all registers return to 0 immediately.
